// File: rtl/vending_pkg.sv
// Shared types for the vending controller: coin encoding, coin values and
// the change-dispenser FSM states.
package vending_pkg;

  typedef enum logic [1:0] {
    QUARTER = 2'd0,
    DIME    = 2'd1,
    NICKEL  = 2'd2,
    PENNY   = 2'd3
  } coin_t;

  localparam int VAL_QUARTER = 25;
  localparam int VAL_DIME    = 10;
  localparam int VAL_NICKEL  = 5;
  localparam int VAL_PENNY   = 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SELECT = 2'd1,
    S_EJECT  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  function automatic logic [4:0] coin_value(input logic [1:0] c);
    case (c)
      2'd0:    return 5'(VAL_QUARTER);
      2'd1:    return 5'(VAL_DIME);
      2'd2:    return 5'(VAL_NICKEL);
      default: return 5'(VAL_PENNY);
    endcase
  endfunction

endpackage

// File: rtl/coin_tube.sv
// One denomination's tube inventory: saturating add of a refill quantity
// and decrement-by-one for an ejected coin, both possible in one cycle.
module coin_tube #(
  parameter int CNT_W      = 8,
  parameter int INIT_COUNT = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic [CNT_W-1:0] qty,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             nonzero
);

  localparam logic [CNT_W:0] MAX = {1'b0, {CNT_W{1'b1}}};

  logic [CNT_W:0] sum, net;

  // Saturate after the decrement so a simultaneous refill+eject nets to
  // min(count+qty-1, max) rather than max-1.
  always_comb begin
    sum = {1'b0, count} + (inc ? {1'b0, qty} : '0);
    net = (dec && sum != '0) ? sum - (CNT_W+1)'(1) : sum;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            count <= CNT_W'(INIT_COUNT);
    else if (net > MAX) count <= MAX[CNT_W-1:0];
    else                count <= net[CNT_W-1:0];
  end

  assign nonzero = (count != '0);

endmodule

// File: rtl/change_dispenser.sv
// Pays out a change amount one coin at a time, greedy largest-first, over a
// req/ack handshake with the coin ejector; reports coins paid and shortfall.
module change_dispenser
  import vending_pkg::*;
#(
  parameter int AMT_W      = 9,
  parameter int CNT_W      = 8,
  parameter int INIT_COUNT = 20,
  parameter int OUT_W      = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [AMT_W-1:0] change_amt,
  output logic             ready,
  output logic             eject_req,
  output logic [1:0]       eject_coin,
  input  logic             eject_ack,
  input  logic             refill_valid,
  input  logic [1:0]       refill_coin,
  input  logic [CNT_W-1:0] refill_qty,
  output logic             done,
  output logic [AMT_W-1:0] shortfall,
  output logic [OUT_W-1:0] quart,
  output logic [OUT_W-1:0] dim,
  output logic [OUT_W-1:0] nick,
  output logic [OUT_W-1:0] pen
);

  state_t                     state, nxt;
  logic [AMT_W-1:0]           remaining;
  logic [3:0][OUT_W-1:0]      paid;
  logic [3:0][CNT_W-1:0]      tube_cnt;
  logic [3:0]                 tube_nz, tube_inc, tube_dec;
  logic                       found, ack_ok;
  coin_t                      sel;

  assign ack_ok = (state == S_EJECT) && eject_ack;

  for (genvar i = 0; i < 4; i++) begin : g_tube
    assign tube_inc[i] = refill_valid && (refill_coin == 2'(i));
    assign tube_dec[i] = ack_ok && (eject_coin == 2'(i));
    coin_tube #(.CNT_W(CNT_W), .INIT_COUNT(INIT_COUNT)) u_tube (
      .clk     (clk),
      .rst     (rst),
      .inc     (tube_inc[i]),
      .qty     (refill_qty),
      .dec     (tube_dec[i]),
      .count   (tube_cnt[i]),
      .nonzero (tube_nz[i])
    );
  end

  // Scan pennies up to quarters so the largest eligible coin wins.
  always_comb begin
    found = 1'b0;
    sel   = QUARTER;
    for (int i = 3; i >= 0; i--) begin
      if (tube_nz[i] && remaining >= AMT_W'(coin_value(2'(i)))) begin
        found = 1'b1;
        sel   = coin_t'(i);
      end
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:   if (start) nxt = S_SELECT;
      S_SELECT: nxt = found ? S_EJECT : S_DONE;
      S_EJECT:  if (eject_ack) nxt = S_SELECT;
      S_DONE:   nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remaining  <= '0;
      paid       <= '0;
      shortfall  <= '0;
      eject_coin <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          remaining <= change_amt;
          paid      <= '0;
          shortfall <= '0;
        end
        S_SELECT: begin
          if (found) eject_coin <= sel;
          else       shortfall  <= remaining;
        end
        S_EJECT: if (eject_ack) begin
          remaining <= remaining - AMT_W'(coin_value(eject_coin));
          if (paid[eject_coin] != '1) paid[eject_coin] <= paid[eject_coin] + OUT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign ready     = (state == S_IDLE);
  assign eject_req = (state == S_EJECT);
  assign done      = (state == S_DONE);
  assign quart     = paid[QUARTER];
  assign dim       = paid[DIME];
  assign nick      = paid[NICKEL];
  assign pen       = paid[PENNY];

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
Downstream stage of the vending controller. It takes the change amount in cents produced when a sale completes and pays it out one coin at a time through a req/ack handshake with the coin-ejector mechanism. It keeps a per-denomination tube inventory and uses greedy largest-coin-first selection. It reports the coins paid out and any shortfall it could not cover.

Parameters:
AMT_W, 9, width of change amount and shortfall (cents, max 511)
CNT_W, 8, width of each tube inventory counter
INIT_COUNT, 20, tube inventory loaded at reset (all four tubes)
OUT_W, 5, width of per-denomination paid-out counters

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle request to pay change_amt; honoured only when ready=1
change_amt  in  AMT_W  change owed, cents; sampled on the accepted start cycle
ready  out  1  high in IDLE only
eject_req  out  1  request ejector to drop one coin of eject_coin
eject_coin  out  2  0=quarter, 1=dime, 2=nickel, 3=penny; stable while eject_req=1
eject_ack  in  1  ejector has dropped the coin; meaningful only while eject_req=1
refill_valid  in  1  one-cycle tube refill strobe
refill_coin  in  2  tube being refilled (same encoding)
refill_qty  in  CNT_W  coins added
done  out  1  one-cycle pulse when payout finishes
shortfall  out  AMT_W  cents not paid; valid from done until next accepted start
quart, dim, nick, pen  out  OUT_W each  coins paid this transaction

Behaviour:
- Reset (async assert): FSM=IDLE, eject_req=0, eject_coin=0, done=0, shortfall=0, all out counters=0, all tubes=INIT_COUNT. Reset mid-eject drops eject_req immediately and abandons the payout.
- States: IDLE, SELECT, EJECT, DONE.
- IDLE: ready=1. On start, latch remaining=change_amt, clear quart/dim/nick/pen and shortfall, go to SELECT. start in any other state is ignored.
- SELECT (1 cycle): choose the largest coin with value<=remaining and tube count>0, in the order quarter(25), dime(10), nickel(5), penny(1).
  - Coin found -> register eject_coin, go to EJECT.
  - remaining==0 -> go to DONE.
  - No eligible coin -> shortfall=remaining, go to DONE.
- EJECT: eject_req=1, eject_coin held. Wait indefinitely for eject_ack. On the ack cycle:
  - remaining -= value, tube -= 1, matching out counter += 1.
  - Go to SELECT, so eject_req is low for at least one cycle between coins.
- DONE: done=1 for exactly one cycle, then IDLE. quart/dim/nick/pen and shortfall hold until the next accepted start.
- Latency: change_amt=0 gives done 2 cycles after the start edge. Each coin costs 1 SELECT cycle plus the EJECT cycles (minimum 1).
- Refill is accepted in every state.
  - Tube becomes min(count+refill_qty, 2^CNT_W-1).
  - If the same tube is also decremented that cycle, the net result is min(count+refill_qty-1, max).
  - A refill landing during SELECT affects that cycle's selection only from the next cycle onward, because tube counts are registered.
- Out counters saturate at 2^OUT_W-1. This is unreachable with default widths (max 20 quarters).
- eject_ack while eject_req=0 is ignored.

Decomposition:
- Shared package vending_pkg:
  - coin_t enum (QUARTER=0, DIME=1, NICKEL=2, PENNY=3)
  - coin value constants 25/10/5/1
  - state enum for this FSM
- One natural sub-module: coin_tube, a saturating up/down inventory counter with parameter INIT_COUNT. It has inc-by-qty and dec-by-1 inputs and count and nonzero outputs. It is instantiated four times.

Test Plan:
1. INIT_COUNT=20, start change_amt=41, ack 1 cycle after each req -> ejects Q,D,N,P in order; quart=dim=nick=pen=1; shortfall=0; one done pulse; tubes 19 each.
2. INIT_COUNT=2, change_amt=100 -> ejects Q,Q,D,D,N,N,P,P; shortfall=18; all counts 2; all tubes 0. Then start 5 -> immediate done, shortfall=5, no eject_req.
3. change_amt=0 -> done exactly 2 cycles after start, no eject_req. A start pulsed during a 41-cent payout is ignored and results match scenario 1.
4. Hold eject_ack low 7 cycles during a quarter eject -> eject_req and eject_coin=0 stable all 7 cycles; stray ack pulses during the req-low gaps change nothing.
5. Quarter tube at 1, payout 50: refill quarter qty 3 on the same cycle as the ack -> tube=3 and the second coin is a quarter. Refill qty 255 onto 20 saturates at 255.
6. Assert rst while eject_req=1 -> eject_req low before the next clock edge; after release ready=1, tubes=INIT_COUNT, counters 0.
